discrete_clk_seq: RTL and testbench
===================================

Name: discrete_clk_seq

Overview:
Sequencer that generates the emulated slow logic clock net (CLK_N) and the power-on clear net (CLR_N) that drive the banks of synchronous discrete flip-flop models, all running on the fast CLK_DRV. It guarantees every emulated high and low phase lasts a minimum number of CLK_DRV cycles, so downstream edge detectors with one-cycle registered history never miss or double-count an edge. It also provides a pause/single-step handshake for debug and verification.

Parameters:
DIV, 4, CLK_DRV cycles per emulated clock period; must be >= 4.
HIGH_CYC, 2, CLK_DRV cycles CLK_N is high per period; must satisfy 2 <= HIGH_CYC <= DIV-2. Low phase length LO_CYC = DIV-HIGH_CYC.
POR_CYC, 16, CLK_DRV cycles CLR_N is held low after reset; must be >= 2.

Ports:
CLK_DRV  in  1  fast system clock; all logic is on its rising edge.
RESET  in  1  synchronous, active-high reset.
PAUSE_REQ  in  1  level request to freeze the emulated clock high.
STEP  in  1  one-cycle pulse; while paused, runs exactly one emulated period.
CLK_N  out  1  emulated clock net, registered.
CLK_FALL  out  1  one-cycle strobe, high in the first cycle CLK_N reads 0.
CLK_RISE  out  1  one-cycle strobe, high in the first cycle CLK_N reads 1 after a low phase.
CLR_N  out  1  power-on clear for the flip-flop models, active low, registered.
PAUSED  out  1  acknowledge: emulated clock is frozen high.
EDGE_CNT  out  16  count of falling edges issued since reset.

Behaviour:
- Interface: one clock (CLK_DRV); reset RESET is synchronous and active-high.
- All outputs are registered. Parameter violations raise an elaboration-time $error.
- Reset values, effective the cycle after RESET is sampled high: state=POR, cnt=0, CLK_N=1, CLR_N=0, CLK_FALL=0, CLK_RISE=0, PAUSED=0, EDGE_CNT=0.
- State POR: CLK_N=1, CLR_N=0, and cnt increments.
  - At cnt==POR_CYC-1: go to HI with cnt=0, and CLR_N=1.
  - CLR_N is therefore low for exactly POR_CYC cycles after RESET is released.
  - CLK_N is never low while CLR_N is low.
- State HI: CLK_N=1, and cnt counts to HIGH_CYC-1.
  - At the terminal count, if PAUSE_REQ=1: go to HOLD with PAUSED=1.
  - Otherwise: go to LO with CLK_N=0, CLK_FALL=1 for one cycle, and EDGE_CNT+1.
  - cnt is cleared on every state change.
- State LO: CLK_N=0, and cnt counts to LO_CYC-1.
  - At the terminal count: go to HI with CLK_N=1 and CLK_RISE=1 for one cycle.
  - PAUSE_REQ and STEP are ignored in LO; a low phase is never truncated.
- State HOLD: CLK_N=1 and PAUSED=1.
  - If PAUSE_REQ=0: go to LO next cycle, with a falling edge as above. The high phase is already satisfied.
  - Else if STEP=1: go to LO and clear PAUSED. After LO and a full HI phase, return to HOLD if PAUSE_REQ is still 1.
  - STEP together with PAUSE_REQ=0 counts as a resume; STEP has no separate effect.
- STEP outside HOLD is ignored and not queued.
- If PAUSE_REQ is asserted during LO, it takes effect at the end of the following HI phase.
- EDGE_CNT is 16-bit unsigned and wraps from 0xFFFF to 0x0000.
- RESET mid-operation, including during LO: the next cycle forces CLK_N=1, CLR_N=0 and the POR state. No CLK_FALL or CLK_RISE is generated by reset itself.
- CLK_FALL and CLK_RISE are never both high, and are never high in POR or HOLD.
- Steady-state period is exactly DIV cycles: HIGH_CYC high, then LO_CYC low.

Test Plan:
- Defaults (DIV=4, HIGH_CYC=2, POR_CYC=16); hold RESET 3 cycles, then release.
  - Required: CLR_N=0 for exactly 16 cycles with CLK_N=1 throughout.
  - Required: first CLK_FALL 2 cycles after CLR_N rises.
  - Required: CLK_N then repeats the pattern 1,1,0,0.
- Free run 100 periods.
  - Required: EDGE_CNT=100.
  - Required: CLK_FALL count = CLK_RISE count = 100 (±1 for an open phase).
  - Required: no high or low phase shorter than 2 cycles.
- Assert PAUSE_REQ in the first LO cycle.
  - Required: LO completes, then HI completes 2 cycles, then PAUSED=1 with CLK_N=1 and EDGE_CNT frozen.
- While paused, pulse STEP 3 times, spaced 10 cycles apart.
  - Required: exactly 3 CLK_FALL pulses, each with a 2-cycle low and 2-cycle high, returning to PAUSED between steps.
  - Required: EDGE_CNT advances by exactly 3.
- Assert RESET during a LO phase.
  - Required: the next cycle has CLK_N=1, CLR_N=0, PAUSED=0, EDGE_CNT=0, with no CLK_RISE strobe.
  - Required: the POR sequence repeats.
- Preload EDGE_CNT near wrap (run 65535 edges, or force in the bench), then run 2 more edges.
  - Required: EDGE_CNT reads 0x0001.

Source files
------------

// File: rtl/discrete_clk_seq.sv
// discrete_clk_seq
// Generates the emulated slow logic clock (CLK_N) and the power-on clear
// (CLR_N) for banks of discrete flip-flop models, all on the fast CLK_DRV.
// Every emulated high and low phase lasts a fixed number of CLK_DRV cycles.
// This lets downstream edge detectors with one cycle of history see each edge
// exactly once. A pause/single-step handshake supports debug.
//
// Ports:
//   CLK_DRV    in   fast system clock, rising edge
//   RESET      in   synchronous active-high reset
//   PAUSE_REQ  in   level request to freeze CLK_N high
//   STEP       in   one-cycle pulse; while paused runs one emulated period
//   CLK_N      out  emulated clock net (registered)
//   CLK_FALL   out  strobe in the first cycle CLK_N reads 0
//   CLK_RISE   out  strobe in the first cycle CLK_N reads 1 after a low phase
//   CLR_N      out  active-low power-on clear (registered)
//   PAUSED     out  emulated clock is frozen high
//   EDGE_CNT   out  falling edges issued since reset (wraps)
module discrete_clk_seq #(
  parameter int DIV      = 4,
  parameter int HIGH_CYC = 2,
  parameter int POR_CYC  = 16
) (
  input  logic        CLK_DRV,
  input  logic        RESET,
  input  logic        PAUSE_REQ,
  input  logic        STEP,
  output logic        CLK_N,
  output logic        CLK_FALL,
  output logic        CLK_RISE,
  output logic        CLR_N,
  output logic        PAUSED,
  output logic [15:0] EDGE_CNT
);

  localparam int LO_CYC  = DIV - HIGH_CYC;
  localparam int CNT_MAX = (POR_CYC > DIV) ? POR_CYC : DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (DIV < 4) begin : g_bad_div
    $error("discrete_clk_seq: DIV must be >= 4");
  end
  if ((HIGH_CYC < 2) || (HIGH_CYC > DIV - 2)) begin : g_bad_high
    $error("discrete_clk_seq: HIGH_CYC must be in [2, DIV-2]");
  end
  if (POR_CYC < 2) begin : g_bad_por
    $error("discrete_clk_seq: POR_CYC must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clk_n_d, clr_n_d, fall_d, rise_d, paused_d;
  logic [15:0]        edge_cnt_d;

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      state_q  <= ST_POR;
      cnt_q    <= '0;
      CLK_N    <= 1'b1;
      CLR_N    <= 1'b0;
      CLK_FALL <= 1'b0;
      CLK_RISE <= 1'b0;
      PAUSED   <= 1'b0;
      EDGE_CNT <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      CLK_N    <= clk_n_d;
      CLR_N    <= clr_n_d;
      CLK_FALL <= fall_d;
      CLK_RISE <= rise_d;
      PAUSED   <= paused_d;
      EDGE_CNT <= edge_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    clk_n_d    = CLK_N;
    clr_n_d    = CLR_N;
    fall_d     = 1'b0;
    rise_d     = 1'b0;
    paused_d   = PAUSED;
    edge_cnt_d = EDGE_CNT;

    unique case (state_q)
      ST_POR: begin
        // Clock is held high for the whole clear so no edge is seen under CLR_N.
        clk_n_d = 1'b1;
        clr_n_d = 1'b0;
        if (cnt_q == CNT_W'(POR_CYC - 1)) begin
          state_d = ST_HI;
          cnt_d   = '0;
          clr_n_d = 1'b1;
        end
      end
      ST_HI: begin
        if (cnt_q == CNT_W'(HIGH_CYC - 1)) begin
          cnt_d = '0;
          // Pause is only honoured after a complete high phase.
          if (PAUSE_REQ) begin
            state_d  = ST_HOLD;
            paused_d = 1'b1;
          end else begin
            state_d    = ST_LO;
            clk_n_d    = 1'b0;
            fall_d     = 1'b1;
            edge_cnt_d = EDGE_CNT + 16'd1;
          end
        end
      end
      ST_LO: begin
        // Low phase always runs to completion; PAUSE_REQ/STEP are not looked at.
        if (cnt_q == CNT_W'(LO_CYC - 1)) begin
          state_d = ST_HI;
          cnt_d   = '0;
          clk_n_d = 1'b1;
          rise_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_d = '0;
        // Resume and single-step both issue an immediate falling edge; the
        // high phase was already satisfied before entering HOLD. A step
        // returns here naturally at the end of the next HI if still paused.
        if (!PAUSE_REQ || STEP) begin
          state_d    = ST_LO;
          clk_n_d    = 1'b0;
          fall_d     = 1'b1;
          paused_d   = 1'b0;
          edge_cnt_d = EDGE_CNT + 16'd1;
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_discrete_clk_seq.sv
// tb_discrete_clk_seq
// Directed bench for discrete_clk_seq with default parameters
// (DIV=4, HIGH_CYC=2, POR_CYC=16). Inputs are driven and outputs sampled on
// the falling edge of CLK_DRV.
module tb_discrete_clk_seq;

  logic        CLK_DRV;
  logic        RESET;
  logic        PAUSE_REQ;
  logic        STEP;
  logic        CLK_N;
  logic        CLK_FALL;
  logic        CLK_RISE;
  logic        CLR_N;
  logic        PAUSED;
  logic [15:0] EDGE_CNT;

  int checks   = 0;
  int failures = 0;

  discrete_clk_seq #(.DIV(4), .HIGH_CYC(2), .POR_CYC(16)) dut (
    .CLK_DRV  (CLK_DRV),
    .RESET    (RESET),
    .PAUSE_REQ(PAUSE_REQ),
    .STEP     (STEP),
    .CLK_N    (CLK_N),
    .CLK_FALL (CLK_FALL),
    .CLK_RISE (CLK_RISE),
    .CLR_N    (CLR_N),
    .PAUSED   (PAUSED),
    .EDGE_CNT (EDGE_CNT)
  );

  initial CLK_DRV = 1'b0;
  always #5 CLK_DRV = ~CLK_DRV;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles with CLR_N low, starting at the current sample, and
  // whether CLK_N stayed high throughout. Leaves the bench on the first
  // sample where CLR_N is high.
  task automatic measure_por(input string tag);
    int lowcnt = 0;
    logic clk_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (CLR_N) break;
      lowcnt++;
      if (!CLK_N) clk_ok = 1'b0;
      @(negedge CLK_DRV);
    end
    chk({tag, "_clr_low_cycles"}, lowcnt, 16);
    chk({tag, "_clk_high_in_por"}, {31'd0, clk_ok}, 1);
  endtask

  initial begin
    int          n;
    int          falls, rises, both, minrun, run;
    logic        prev;
    logic [15:0] e0;
    logic [7:0]  pat8;
    logic [9:0]  pat10;

    RESET = 1'b1; PAUSE_REQ = 1'b0; STEP = 1'b0;
    repeat (3) @(posedge CLK_DRV);
    @(negedge CLK_DRV);

    // Reset state
    chk("rst_clk_n",    {31'd0, CLK_N},    1);
    chk("rst_clr_n",    {31'd0, CLR_N},    0);
    chk("rst_fall",     {31'd0, CLK_FALL}, 0);
    chk("rst_rise",     {31'd0, CLK_RISE}, 0);
    chk("rst_paused",   {31'd0, PAUSED},   0);
    chk("rst_edge_cnt", {16'd0, EDGE_CNT}, 0);

    // Power-on clear
    RESET = 1'b0;
    measure_por("por1");

    // First falling edge two cycles after CLR_N rises
    n = 0;
    while (!CLK_FALL && n < 20) begin
      @(negedge CLK_DRV);
      n++;
    end
    chk("first_fall_delay", n, 2);
    chk("first_fall_edge_cnt", {16'd0, EDGE_CNT}, 1);

    // Steady pattern from the falling edge: 0,0,1,1,0,0,1,1
    pat8 = '0;
    for (int i = 0; i < 8; i++) begin
      pat8 = {pat8[6:0], CLK_N};
      @(negedge CLK_DRV);
    end
    chk("clk_pattern", {24'd0, pat8}, 32'h33);

    // Free run 100 periods (starting on a falling-edge cycle)
    e0 = EDGE_CNT;
    falls = 0; rises = 0; both = 0; minrun = 1000; run = 0; prev = CLK_N;
    for (int i = 0; i < 400; i++) begin
      if (CLK_FALL) falls++;
      if (CLK_RISE) rises++;
      if (CLK_FALL && CLK_RISE) both++;
      if (CLK_N != prev) begin
        if (run < minrun) minrun = run;
        run = 1;
        prev = CLK_N;
      end else begin
        run++;
      end
      @(negedge CLK_DRV);
    end
    chk("run_edge_delta", {16'd0, EDGE_CNT - e0}, 100);
    chk("run_fall_count", falls, 100);
    chk("run_rise_count", rises, 100);
    chk("run_min_phase",  minrun, 2);
    chk("run_both_strobes", both, 0);

    // Pause requested in the first LO cycle
    chk("pause_start_in_fall", {31'd0, CLK_FALL}, 1);
    e0 = EDGE_CNT;
    PAUSE_REQ = 1'b1;
    n = 0; pat8 = '0;
    while (!PAUSED && n < 20) begin
      pat8 = {pat8[6:0], CLK_N};
      @(negedge CLK_DRV);
      n++;
    end
    chk("pause_latency", n, 4);
    chk("pause_phases", {28'd0, pat8[3:0]}, 32'h3);
    chk("pause_clk_high", {31'd0, CLK_N}, 1);
    repeat (5) @(negedge CLK_DRV);
    chk("pause_still_paused", {31'd0, PAUSED}, 1);
    chk("pause_edge_frozen", {16'd0, EDGE_CNT}, {16'd0, e0});
    chk("pause_no_fall", {31'd0, CLK_FALL}, 0);

    // Three single steps, 10 cycles apart
    falls = 0;
    for (int s = 0; s < 3; s++) begin
      STEP = 1'b1;
      pat10 = '0;
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK_DRV);
        STEP = 1'b0;
        pat10 = {pat10[8:0], CLK_N};
        if (CLK_FALL) falls++;
      end
      chk($sformatf("step%0d_pattern", s), {22'd0, pat10}, 32'h0FF);
      chk($sformatf("step%0d_repaused", s), {31'd0, PAUSED}, 1);
    end
    chk("step_fall_count", falls, 3);
    chk("step_edge_delta", {16'd0, EDGE_CNT - e0}, 3);

    // Resume, then reset in the middle of the low phase
    PAUSE_REQ = 1'b0;
    @(negedge CLK_DRV);
    chk("resume_fall", {31'd0, CLK_FALL}, 1);
    chk("resume_paused", {31'd0, PAUSED}, 0);
    chk("resume_edge_cnt", {16'd0, EDGE_CNT}, {16'd0, e0 + 16'd4});
    @(negedge CLK_DRV);
    chk("lo_before_reset", {31'd0, CLK_N}, 0);
    RESET = 1'b1;
    @(negedge CLK_DRV);
    chk("rst2_clk_n",    {31'd0, CLK_N},    1);
    chk("rst2_clr_n",    {31'd0, CLR_N},    0);
    chk("rst2_paused",   {31'd0, PAUSED},   0);
    chk("rst2_edge_cnt", {16'd0, EDGE_CNT}, 0);
    chk("rst2_no_rise",  {31'd0, CLK_RISE}, 0);
    chk("rst2_no_fall",  {31'd0, CLK_FALL}, 0);
    RESET = 1'b0;
    measure_por("por2");

    // Counter wrap: preload 0xFFFF during the first HI cycle
    force dut.EDGE_CNT = 16'hFFFF;
    @(negedge CLK_DRV);
    release dut.EDGE_CNT;
    chk("wrap_preload", {16'd0, EDGE_CNT}, 32'hFFFF);
    @(negedge CLK_DRV);
    chk("wrap_fall", {31'd0, CLK_FALL}, 1);
    chk("wrap_zero", {16'd0, EDGE_CNT}, 0);
    n = 0;
    do begin
      @(negedge CLK_DRV);
      n++;
    end while (!CLK_FALL && n < 10);
    chk("wrap_period", n, 4);
    chk("wrap_one", {16'd0, EDGE_CNT}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
